// File: rtl/hazard_mdu_ctrl_pkg.sv
// Shared encodings, defaults and hazard helper for the pipeline hazard controller.
package hazard_mdu_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_W  = 2'd1,
        FWD_M  = 2'd2,
        FWD_E  = 2'd3
    } fwd_e;

    localparam logic [1:0]  TUSE_NONE       = 2'd3;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    // True when the producer at wa will not have its result ready by the time src is consumed.
    function automatic logic reg_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                        input logic [4:0] wa, input logic [1:0] tnew);
        return (src != 5'd0) && (tuse != TUSE_NONE) && (src == wa) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/hazard_mdu_ctrl_md_busy_counter.sv
// Mult/div busy counter: loads the operation latency on start, counts down to idle.
module hazard_mdu_ctrl_md_busy_counter #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    logic [CNT_W-1:0] count;

    // A start arriving while already busy cannot happen upstream; it is ignored rather than reloading.
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (start && (count == '0))
            count <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        else if (count != '0)
            count <= count - CNT_W'(1);
    end

    assign busy = (count != '0);

endmodule

// File: rtl/hazard_mdu_ctrl.sv
// Hazard controller for the 5-stage pipeline: stall generation, D/E forwarding selects, MDU sequencing.
module hazard_mdu_ctrl
    import hazard_mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_rs_tuse,
    input  logic [1:0]  D_rt_tuse,
    input  logic        D_is_md,
    input  logic [4:0]  E_rs,
    input  logic [4:0]  E_rt,
    input  logic [4:0]  E_wa,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_wa,
    input  logic [1:0]  M_tnew,
    input  logic [4:0]  W_wa,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        stall,
    output logic        F_en,
    output logic        D_en,
    output logic        E_clr,
    output logic [1:0]  D_fwd_rs,
    output logic [1:0]  D_fwd_rt,
    output logic [1:0]  E_fwd_rs,
    output logic [1:0]  E_fwd_rt,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    logic rs_haz, rt_haz, md_haz;

    function automatic fwd_e d_fwd(input logic [4:0] src);
        if (src == 5'd0)                          return FWD_RF;
        else if (src == E_wa && E_tnew == 2'd0)   return FWD_E;
        else if (src == M_wa && M_tnew == 2'd0)   return FWD_M;
        else if (src == W_wa)                     return FWD_W;
        else                                      return FWD_RF;
    endfunction

    function automatic fwd_e e_fwd(input logic [4:0] src);
        if (src == 5'd0)                          return FWD_RF;
        else if (src == M_wa && M_tnew == 2'd0)   return FWD_M;
        else if (src == W_wa)                     return FWD_W;
        else                                      return FWD_RF;
    endfunction

    hazard_mdu_ctrl_md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_counter (
        .clk    (clk),
        .reset  (reset),
        .start  (E_md_start),
        .is_div (E_md_div),
        .busy   (md_busy)
    );

    always_comb begin
        rs_haz   = reg_hazard(D_rs, D_rs_tuse, E_wa, E_tnew) | reg_hazard(D_rs, D_rs_tuse, M_wa, M_tnew);
        rt_haz   = reg_hazard(D_rt, D_rt_tuse, E_wa, E_tnew) | reg_hazard(D_rt, D_rt_tuse, M_wa, M_tnew);
        md_haz   = D_is_md && (md_busy || E_md_start);
        stall    = rs_haz | rt_haz | md_haz;
        F_en     = ~stall;
        D_en     = ~stall;
        E_clr    = stall;
        D_fwd_rs = d_fwd(D_rs);
        D_fwd_rt = d_fwd(D_rt);
        E_fwd_rs = e_fwd(E_rs);
        E_fwd_rt = e_fwd(E_rt);
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall)
            stall_cnt <= stall_cnt + 32'd1;
    end

endmodule

// File: tb/tb_hazard_mdu_ctrl.sv
// Directed self-checking bench for hazard_mdu_ctrl.
module tb_hazard_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs, D_rt, E_rs, E_rt, E_wa, M_wa, W_wa;
    logic [1:0]  D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
    logic        D_is_md, E_md_start, E_md_div;
    logic        stall, F_en, D_en, E_clr, md_busy;
    logic [1:0]  D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt;
    logic [31:0] stall_cnt;

    int unsigned total  = 0;
    int unsigned passed = 0;
    logic [31:0] exp_cnt = 0;

    always #5 clk = ~clk;

    hazard_mdu_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_rs_tuse  (D_rs_tuse),
        .D_rt_tuse  (D_rt_tuse),
        .D_is_md    (D_is_md),
        .E_rs       (E_rs),
        .E_rt       (E_rt),
        .E_wa       (E_wa),
        .E_tnew     (E_tnew),
        .M_wa       (M_wa),
        .M_tnew     (M_tnew),
        .W_wa       (W_wa),
        .E_md_start (E_md_start),
        .E_md_div   (E_md_div),
        .stall      (stall),
        .F_en       (F_en),
        .D_en       (D_en),
        .E_clr      (E_clr),
        .D_fwd_rs   (D_fwd_rs),
        .D_fwd_rt   (D_fwd_rt),
        .E_fwd_rs   (E_fwd_rs),
        .E_fwd_rt   (E_fwd_rt),
        .md_busy    (md_busy),
        .stall_cnt  (stall_cnt)
    );

    always @(posedge clk) begin
        if (!reset && E_md_start && md_busy)
            $error("E_md_start asserted while md_busy");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        D_rs = 0; D_rt = 0; D_rs_tuse = 2'd3; D_rt_tuse = 2'd3; D_is_md = 0;
        E_rs = 0; E_rt = 0; E_wa = 0; E_tnew = 0; M_wa = 0; M_tnew = 0; W_wa = 0;
        E_md_start = 0; E_md_div = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        D_rs_tuse = 0; D_rt_tuse = 0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        exp_cnt = 0;
        #1;
        total++; if (md_busy !== 1'b0) $display("FAIL reset_md_busy got %b want 0", md_busy); else passed++;
        total++; if (stall_cnt !== 32'd0) $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); else passed++;
        total++; if ({stall, F_en, D_en, E_clr} !== 4'b0110) $display("FAIL reset_ctrl got %b want 0110", {stall, F_en, D_en, E_clr}); else passed++;
        total++; if ({D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt} !== 8'h00) $display("FAIL reset_fwd got %h want 00", {D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt}); else passed++;
    endtask

    task automatic test_load_use();
        clear_inputs();
        E_wa = 8; E_tnew = 2; D_rs = 8; D_rs_tuse = 1;
        #1;
        total++; if ({stall, F_en, D_en, E_clr} !== 4'b1001) $display("FAIL load_use_ctrl got %b want 1001", {stall, F_en, D_en, E_clr}); else passed++;
        total++; if (D_fwd_rs !== 2'd0) $display("FAIL load_use_fwd got %0d want 0", D_fwd_rs); else passed++;
        exp_cnt++;
        tick();
        total++; if (stall_cnt !== exp_cnt) $display("FAIL load_use_cnt got %0d want %0d", stall_cnt, exp_cnt); else passed++;
        E_wa = 0;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL load_use_release got %b want 0", stall); else passed++;
        // tuse == tnew is just in time: no stall
        E_wa = 8; E_tnew = 1;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL tuse_eq_tnew got %b want 0", stall); else passed++;
        // M-stage producer on rt with tuse 0
        clear_inputs();
        M_wa = 12; M_tnew = 1; D_rt = 12; D_rt_tuse = 0;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL m_hazard_rt got %b want 1", stall); else passed++;
        exp_cnt++;
        tick();
        D_rt_tuse = 3;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL tuse_none got %b want 0", stall); else passed++;
        total++; if (stall_cnt !== exp_cnt) $display("FAIL m_hazard_cnt got %0d want %0d", stall_cnt, exp_cnt); else passed++;
    endtask

    task automatic test_d_forward();
        clear_inputs();
        E_wa = 9; E_tnew = 0; M_wa = 9; M_tnew = 0; W_wa = 9; D_rt = 9; D_rt_tuse = 1;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL alu_b2b_stall got %b want 0", stall); else passed++;
        total++; if (D_fwd_rt !== 2'd3) $display("FAIL d_fwd_e got %0d want 3", D_fwd_rt); else passed++;
        E_wa = 0;
        #1;
        total++; if (D_fwd_rt !== 2'd2) $display("FAIL d_fwd_m got %0d want 2", D_fwd_rt); else passed++;
        M_wa = 0;
        #1;
        total++; if (D_fwd_rt !== 2'd1) $display("FAIL d_fwd_w got %0d want 1", D_fwd_rt); else passed++;
        W_wa = 3;
        #1;
        total++; if (D_fwd_rt !== 2'd0) $display("FAIL d_fwd_rf got %0d want 0", D_fwd_rt); else passed++;
    endtask

    task automatic test_zero_guard();
        clear_inputs();
        E_wa = 0; E_tnew = 2; D_rs = 0; D_rs_tuse = 0; M_wa = 0; M_tnew = 0; W_wa = 0;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL zero_guard_stall got %b want 0", stall); else passed++;
        total++; if (D_fwd_rs !== 2'd0) $display("FAIL zero_guard_fwd got %0d want 0", D_fwd_rs); else passed++;
        E_rs = 0;
        #1;
        total++; if (E_fwd_rs !== 2'd0) $display("FAIL zero_guard_efwd got %0d want 0", E_fwd_rs); else passed++;
    endtask

    task automatic test_e_forward();
        clear_inputs();
        M_wa = 5; M_tnew = 0; W_wa = 5; E_rs = 5;
        #1;
        total++; if (E_fwd_rs !== 2'd2) $display("FAIL e_fwd_m got %0d want 2", E_fwd_rs); else passed++;
        M_wa = 0;
        #1;
        total++; if (E_fwd_rs !== 2'd1) $display("FAIL e_fwd_w got %0d want 1", E_fwd_rs); else passed++;
        M_wa = 6; M_tnew = 1; W_wa = 6; E_rt = 6;
        #1;
        total++; if (E_fwd_rt !== 2'd1) $display("FAIL e_fwd_m_notready got %0d want 1", E_fwd_rt); else passed++;
        total++; if (E_fwd_rs !== 2'd0) $display("FAIL e_fwd_none got %0d want 0", E_fwd_rs); else passed++;
    endtask

    task automatic test_md(input logic is_div, input int unsigned n);
        clear_inputs();
        // register hazard and MDU hazard together on the start cycle
        D_is_md = 1; E_md_start = 1; E_md_div = is_div;
        E_wa = 8; E_tnew = 2; D_rs = 8; D_rs_tuse = 0;
        #1;
        total++; if ({stall, md_busy} !== 2'b10) $display("FAIL md_start got %b want 10 (div=%b)", {stall, md_busy}, is_div); else passed++;
        exp_cnt++;
        tick();
        total++; if (stall_cnt !== exp_cnt) $display("FAIL md_dual_cnt got %0d want %0d", stall_cnt, exp_cnt); else passed++;
        E_md_start = 0; E_wa = 0; E_tnew = 0; D_rs = 0;
        for (int unsigned i = 1; i <= n; i++) begin
            #1;
            total++; if ({stall, md_busy} !== 2'b11) $display("FAIL md_busy_cycle%0d got %b want 11 (div=%b)", i, {stall, md_busy}, is_div); else passed++;
            exp_cnt++;
            tick();
        end
        #1;
        total++; if ({stall, md_busy} !== 2'b00) $display("FAIL md_release got %b want 00 (div=%b)", {stall, md_busy}, is_div); else passed++;
        total++; if (stall_cnt !== exp_cnt) $display("FAIL md_cnt got %0d want %0d", stall_cnt, exp_cnt); else passed++;
    endtask

    task automatic test_reset_mid_div();
        clear_inputs();
        D_is_md = 1; E_md_start = 1; E_md_div = 1;
        tick();
        E_md_start = 0;
        tick(); tick(); tick();
        #1;
        total++; if (md_busy !== 1'b1) $display("FAIL mid_div_busy got %b want 1", md_busy); else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_cnt = 0;
        #1;
        total++; if (md_busy !== 1'b0) $display("FAIL mid_div_reset_busy got %b want 0", md_busy); else passed++;
        total++; if (stall_cnt !== 32'd0) $display("FAIL mid_div_reset_cnt got %0d want 0", stall_cnt); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL mid_div_reset_stall got %b want 0", stall); else passed++;
        tick();
        total++; if (stall_cnt !== exp_cnt) $display("FAIL mid_div_idle_cnt got %0d want %0d", stall_cnt, exp_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_d_forward();
        test_zero_guard();
        test_e_forward();
        test_md(1'b1, 10);
        test_md(1'b0, 5);
        test_reset_mid_div();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_mdu_ctrl.md
Name: hazard_mdu_ctrl

Overview:
- Central hazard controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Per cycle it decides:
  - Stall: hold F and D registers, bubble into E register.
  - D-stage and E-stage forwarding selects, from Tuse/Tnew and register addresses.
- Owns a multi-cycle mult/div busy counter that sequences the HI/LO unit and blocks dependent instructions.
- Drives the enable/clear pins of the F/D/E pipeline registers; M and W registers always advance.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.
- CNT_W, 4, busy-counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- D_rs, D_rt  in  5 each  source registers of instr in D
- D_rs_tuse, D_rt_tuse  in  2 each  cycles until operand needed (3 = unused)
- D_is_md  in  1  D instr reads/writes HI/LO or is mult/div
- E_rs, E_rt  in  5 each  source registers of instr in E
- E_wa  in  5  E-stage destination register (0 = none)
- E_tnew  in  2  cycles until E result available
- M_wa  in  5  M-stage destination register
- M_tnew  in  2  cycles until M result available
- W_wa  in  5  W-stage destination register (Tnew always 0)
- E_md_start  in  1  mult/div in E and not a bubble
- E_md_div  in  1  1 = div/divu, 0 = mult/multu; valid with E_md_start
- stall  out  1  pipeline stall this cycle
- F_en, D_en  out  1 each  PC / D-register write enable (= ~stall)
- E_clr  out  1  clear E register to nop (= stall)
- D_fwd_rs, D_fwd_rt  out  2 each  0 RF, 1 W, 2 M, 3 E
- E_fwd_rs, E_fwd_rt  out  2 each  0 reg value, 1 W, 2 M
- md_busy  out  1  mult/div unit busy
- stall_cnt  out  32  total stall cycles since reset

Behaviour:
- Reset: clk and reset per decision above (synchronous, active-high).
  - On reset, busy counter and stall_cnt go to 0, so md_busy=0.
  - stall and forward outputs are combinational; with all-zero inputs they evaluate to stall=0, F_en=D_en=1, E_clr=0, all fwd=0.
- Register-hazard stall, per source s in {rs, rt}, with s != 0:
  - (D_s == E_wa) && (D_s_tuse < E_tnew), or
  - (D_s == M_wa) && (D_s_tuse < M_tnew).
- MDU stall: D_is_md && (md_busy || E_md_start).
- stall = OR of all of the above. Then F_en = D_en = ~stall and E_clr = stall.
- D forwarding, priority E > M > W > RF, register 0 never forwarded:
  - 3 if D_s == E_wa && E_tnew == 0
  - else 2 if D_s == M_wa && M_tnew == 0
  - else 1 if D_s == W_wa
  - else 0
- E forwarding, priority M > W:
  - 2 if E_s == M_wa && M_tnew == 0
  - else 1 if E_s == W_wa
  - else 0
- Busy counter:
  - At the posedge with E_md_start=1 it loads DIV_CYCLES or MULT_CYCLES.
  - Otherwise it decrements while nonzero.
  - md_busy = (count != 0).
  - Start at edge t → md_busy high for cycles t+1 .. t+N exactly.
  - E_md_start while md_busy is impossible by construction: ignored (count not reloaded), flagged by bench assertion.
- stall_cnt increments on every posedge where stall=1 and reset=0; wraps at 2^32.
- Reset mid-operation (busy mid-count) clears count immediately, so md_busy=0 next cycle.
- Simultaneous register hazard and MDU hazard: a single stall, stall_cnt +1.

Decomposition:
- Shared package/header holds:
  - FWD_RF/W/M/E encodings
  - TUSE_NONE = 3
  - MULT_CYCLES / DIV_CYCLES defaults
- One natural sub-module: md_busy_counter (load/decrement/busy flag).
- Stall and forwarding logic stay in the top module.

Test Plan:
- Load-use hazard: E_wa=8, E_tnew=2, D_rs=8, D_rs_tuse=1 → stall=1, F_en=0, E_clr=1, stall_cnt +1. Next cycle E_wa=0 → stall=0.
- ALU back-to-back: E_wa=9, E_tnew=0, M_wa=9, D_rt=9, D_rt_tuse=1 → stall=0, D_fwd_rt=3 (E beats M).
- $0 guard: E_wa=0, E_tnew=2, D_rs=0, D_rs_tuse=0 → stall=0, D_fwd_rs=0.
- Div sequencing: E_md_start=1, E_md_div=1 at edge t with D_is_md=1 → stall that cycle; md_busy high exactly 10 cycles; stall released at cycle t+11. Mult variant gives 5 cycles.
- Reset mid-div: reset at busy cycle 4 → md_busy=0 and stall_cnt=0 next cycle; D_is_md no longer stalls.
- E forwarding: M_wa=5, M_tnew=0, W_wa=5, E_rs=5 → E_fwd_rs=2. With M_wa=0 → E_fwd_rs=1.
